fetch_prefetch_queue: RTL and testbench



---
 rtl/fetch_prefetch_queue.sv | 121 ++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front end: owns the PC, issues in-order imem requests and buffers responses
// in a DEPTH-entry prefetch queue. Optional macro FETCH_BYPASS_EN forwards a head-filling response to decode.
module fetch_prefetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int unsigned      PTR_W    = $clog2(DEPTH),
  localparam int unsigned      CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectPC,
  output logic              IMemReq,
  output logic [ADDR_W-1:0] IMemAddr,
  input  logic              IMemGnt,
  input  logic              IMemRespValid,
  input  logic [DATA_W-1:0] IMemRespData,
  output logic              InstrValid,
  output logic [DATA_W-1:0] Instruction,
  output logic [ADDR_W-1:0] PCPlusFour,
  input  logic              InstrReady,
  output logic [CNT_W-1:0]  Occupancy
);

  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);
  localparam logic [CNT_W:0]    DEPTH_EXT = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  alloc;     // allocated entries, filled or not
  logic [CNT_W-1:0]  pending;   // allocated entries still waiting for data
  logic [CNT_W-1:0]  drop_cnt;  // stale responses still to be discarded
  logic [PTR_W-1:0]  head;

  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0] pc4_q   [DEPTH];

  logic [CNT_W-1:0]  filled_cnt;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  fill_ptr;
  logic [CNT_W:0]    in_use;
  logic              grant;
  logic              resp_drop;
  logic              resp_fill;
  logic              head_filled;
  logic              bypass;
  logic              pop;
  logic              write_fill;

  // Filled entries form a contiguous run starting at head, so the oldest
  // unfilled slot sits right after them.
  assign filled_cnt  = alloc - pending;
  assign tail        = head + alloc[PTR_W-1:0];
  assign fill_ptr    = head + filled_cnt[PTR_W-1:0];
  assign in_use      = {1'b0, alloc} + {1'b0, drop_cnt};

  assign IMemReq     = Reset_n & ~Redirect & (in_use < DEPTH_EXT);
  assign IMemAddr    = pc;
  assign grant       = IMemReq & IMemGnt;

  assign resp_drop   = IMemRespValid & (drop_cnt != '0);
  assign resp_fill   = IMemRespValid & (drop_cnt == '0) & (pending != '0);
  assign head_filled = (filled_cnt != '0);

`ifdef FETCH_BYPASS_EN
  // A fill with no filled entries ahead of it necessarily targets the head.
  assign bypass      = resp_fill & ~head_filled;
`else
  assign bypass      = 1'b0;
`endif

  assign InstrValid  = head_filled | bypass;
  assign Instruction = bypass ? IMemRespData : instr_q[head];
  assign PCPlusFour  = pc4_q[head];
  assign Occupancy   = alloc;

  assign pop         = InstrValid & InstrReady;
  assign write_fill  = resp_fill & ~(bypass & pop);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pc       <= RESET_PC;
      alloc    <= '0;
      pending  <= '0;
      drop_cnt <= '0;
      head     <= '0;
    end else if (Redirect) begin
      // Unfilled entries turn into responses that must be thrown away.
      pc       <= RedirectPC;
      alloc    <= '0;
      pending  <= '0;
      head     <= '0;
      drop_cnt <= (pending - CNT_W'(resp_fill)) + (drop_cnt - CNT_W'(resp_drop));
    end else begin
      if (grant) begin
        pc <= pc + PC_STEP;
      end
      alloc    <= alloc + CNT_W'(grant) - CNT_W'(pop);
      pending  <= pending + CNT_W'(grant) - CNT_W'(resp_fill);
      drop_cnt <= drop_cnt - CNT_W'(resp_drop);
      head     <= head + PTR_W'(pop);
    end
  end

  // NOTE: the payload arrays carry no reset; validity is tracked by the
  // counters above, so reset only the control state and keep storage plain.
  always_ff @(posedge Clock) begin
    if (grant) begin
      pc4_q[tail] <= pc + PC_STEP;
    end
    if (write_fill) begin
      instr_q[fill_ptr] <= IMemRespData;
    end
  end

  // A response with nothing to fill and nothing to drop is a memory protocol error.
  resp_orphan_a: assert property (@(posedge Clock) disable iff (!Reset_n)
    !(IMemRespValid && (drop_cnt == '0) && (pending == '0)));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: behavioural memory plus a scoreboard of expected
// decode entries; directed scenarios followed by a short random stretch.
module tb_fetch_prefetch_queue;

  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
  localparam bit BYPASS          = 1'b1;
  localparam int FIRST_VALID_CYC = 1;
`else
  localparam bit BYPASS          = 1'b0;
  localparam int FIRST_VALID_CYC = 2;
`endif

  logic              Clock = 1'b0;
  logic              Reset_n = 1'b0;
  logic              Redirect = 1'b0;
  logic [ADDR_W-1:0] RedirectPC = '0;
  logic              IMemReq;
  logic [ADDR_W-1:0] IMemAddr;
  logic              IMemGnt = 1'b0;
  logic              IMemRespValid = 1'b0;
  logic [DATA_W-1:0] IMemRespData = '0;
  logic              InstrValid;
  logic [DATA_W-1:0] Instruction;
  logic [ADDR_W-1:0] PCPlusFour;
  logic              InstrReady = 1'b0;
  logic [2:0]        Occupancy;

  fetch_prefetch_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt),
    .IMemRespValid(IMemRespValid), .IMemRespData(IMemRespData),
    .InstrValid(InstrValid), .Instruction(Instruction), .PCPlusFour(PCPlusFour),
    .InstrReady(InstrReady), .Occupancy(Occupancy)
  );

  always #5 Clock = ~Clock;

  typedef struct { logic [31:0] addr; int due; bit stale; } mem_req_t;
  typedef struct { logic [31:0] pc4; logic [31:0] instr; bit filled; } sb_ent_t;

  mem_req_t    mem_q[$];
  sb_ent_t     sb_q[$];
  logic [31:0] pop_log[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          lat;
  int          last_due;
  int          grants;
  int          first_valid_cyc;
  bit          gnt;
  bit          ready;
  bit          popped;
  bit          s_req;
  logic [31:0] exp_pc;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    mem_q.delete();
    sb_q.delete();
    pop_log.delete();
    exp_pc          = RESET_PC;
    cyc             = 0;
    last_due        = -1;
    grants          = 0;
    first_valid_cyc = -1;
  endtask

  // Called at a falling edge; drives one cycle, checks it, updates the model, returns at the next falling edge.
  task automatic step(input bit redir, input logic [31:0] rpc);
    mem_req_t r;
    sb_ent_t  e;
    bit       resp, fills, exp_req, exp_valid;
    int       stale_cnt, due;
    Redirect   = redir;
    RedirectPC = rpc;
    IMemGnt    = gnt;
    InstrReady = ready;
    resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    IMemRespValid = resp;
    IMemRespData  = resp ? imem_word(mem_q[0].addr) : 32'h0;
    #1;
    stale_cnt = 0;
    foreach (mem_q[i]) if (mem_q[i].stale) stale_cnt++;
    fills     = resp && !mem_q[0].stale;
    exp_req   = !redir && ((sb_q.size() + stale_cnt) < DEPTH);
    exp_valid = (sb_q.size() > 0) && (sb_q[0].filled || (BYPASS && fills));
    check("imem_req", 64'(IMemReq), 64'(exp_req));
    check("imem_addr", 64'(IMemAddr), 64'(exp_pc));
    check("occupancy", 64'(Occupancy), 64'(sb_q.size()));
    check("instr_valid", 64'(InstrValid), 64'(exp_valid));
    if (InstrValid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (InstrValid && ready) begin
      popped = 1'b1;
      pop_log.push_back(PCPlusFour);
      check("pop_has_entry", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        check("pc_plus_four", 64'(PCPlusFour), 64'(sb_q[0].pc4));
        check("instruction", 64'(Instruction), 64'(sb_q[0].instr));
      end
    end
    s_req = IMemReq;
    if (resp) begin
      r = mem_q.pop_front();
      if (!r.stale) begin
        for (int i = 0; i < sb_q.size(); i++) begin
          if (!sb_q[i].filled) begin
            e = sb_q[i]; e.filled = 1'b1; sb_q[i] = e;
            break;
          end
        end
      end
    end
    if (exp_valid && ready && sb_q.size() > 0) void'(sb_q.pop_front());
    if (IMemReq && gnt) begin
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      r.addr = IMemAddr; r.due = due; r.stale = 1'b0;
      mem_q.push_back(r);
      e.pc4 = exp_pc + 32'd4; e.instr = imem_word(exp_pc); e.filled = 1'b0;
      sb_q.push_back(e);
      exp_pc = exp_pc + 32'd4;
      grants++;
    end
    if (redir) begin
      for (int i = 0; i < mem_q.size(); i++) begin
        r = mem_q[i]; r.stale = 1'b1; mem_q[i] = r;
      end
      sb_q.delete();
      exp_pc = rpc;
    end
    cyc++;
    @(negedge Clock);
  endtask

  task automatic apply_reset();
    Reset_n = 1'b0; Redirect = 1'b0; IMemGnt = 1'b0; IMemRespValid = 1'b0; InstrReady = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    check("rst_req", 64'(IMemReq), 64'd0);
    check("rst_valid", 64'(InstrValid), 64'd0);
    check("rst_occupancy", 64'(Occupancy), 64'd0);
    check("rst_addr", 64'(IMemAddr), 64'(RESET_PC));
    Reset_n = 1'b1;
    clear_model();
  endtask

  initial begin
    @(negedge Clock);

    // Zero-wait memory streaming from reset
    apply_reset();
    lat = 1; gnt = 1'b1; ready = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0);
    check("first_valid_cycle", 64'(first_valid_cyc), 64'(FIRST_VALID_CYC));
    check("stream_pops", 64'(pop_log.size()), 64'(12 - FIRST_VALID_CYC));
    if (pop_log.size() >= 2) begin
      check("stream_first_pc4", 64'(pop_log[0]), 64'h4);
      check("stream_second_pc4", 64'(pop_log[1]), 64'h8);
    end

    // Stall: queue fills, request drops, resumes one cycle after a pop
    apply_reset();
    lat = 1; gnt = 1'b1; ready = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0);
    check("stall_grants", 64'(grants), 64'd4);
    check("stall_req_low", 64'(s_req), 64'd0);
    check("stall_occupancy", 64'(Occupancy), 64'd4);
    ready = 1'b1;
    step(1'b0, 32'h0);
    check("pop_cycle_req", 64'(s_req), 64'd0);
    ready = 1'b0;
    step(1'b0, 32'h0);
    check("after_pop_req", 64'(s_req), 64'd1);
    step(1'b0, 32'h0);

    // Slow memory, two outstanding, redirect discards both stale responses
    apply_reset();
    lat = 3; gnt = 1'b1; ready = 1'b1;
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    gnt = 1'b0;
    step(1'b1, 32'h100);
    gnt = 1'b1;
    popped = 1'b0;
    pop_log.delete();
    for (int i = 0; i < 20 && !popped; i++) step(1'b0, 32'h0);
    check("redirect_popped", 64'(popped), 64'd1);
    if (pop_log.size() > 0) check("redirect_first_pc4", 64'(pop_log[0]), 64'h104);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0);

    // Redirect coinciding with a pop and a response
    apply_reset();
    lat = 1; gnt = 1'b1; ready = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0);
    popped = 1'b0;
    step(1'b1, 32'h200);
    check("redirect_cycle_pop", 64'(popped), 64'd1);
    check("redirect_occupancy", 64'(Occupancy), 64'd0);
    check("redirect_addr", 64'(IMemAddr), 64'h200);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0);

    // Asynchronous reset mid-stream with three entries held
    apply_reset();
    lat = 1; gnt = 1'b1; ready = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
    gnt = 1'b0;
    for (int i = 0; i < 2; i++) step(1'b0, 32'h0);
    check("pre_reset_occupancy", 64'(Occupancy), 64'd3);
    check("pre_reset_valid", 64'(InstrValid), 64'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(InstrValid), 64'd0);
    check("async_rst_occupancy", 64'(Occupancy), 64'd0);
    check("async_rst_addr", 64'(IMemAddr), 64'(RESET_PC));
    check("async_rst_req", 64'(IMemReq), 64'd0);
    @(negedge Clock);
    apply_reset();

    // PC wrap at the top of the address space
    lat = 1; gnt = 1'b0; ready = 1'b1;
    step(1'b1, 32'hFFFF_FFF8);
    gnt = 1'b1;
    pop_log.delete();
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    check("wrap_addr", 64'(IMemAddr), 64'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0);
    check("wrap_pops", 64'(pop_log.size() >= 2), 64'd1);
    if (pop_log.size() >= 2) check("wrap_pc4", 64'(pop_log[1]), 64'h0);

    // Random grants, stalls, latencies and redirects
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      gnt   = ($urandom_range(0, 3) != 0);
      ready = ($urandom_range(0, 3) != 0);
      lat   = $urandom_range(1, 4);
      if ($urandom_range(0, 19) == 0) step(1'b1, $urandom() & 32'hFFFF_FFFC);
      else step(1'b0, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
